// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT sequencer: state encoding,
// RAM write-source encoding and the bit-reversal helper.
package fft_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_UNLOAD  = 2'd3
  } state_e;

  localparam logic SEL_EXT = 1'b0;
  localparam logic SEL_BF  = 1'b1;

  // Reverses the low aw bits of x by shifting them out LSB-first.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int aw);
    logic [31:0] v;
    logic [31:0] r;
    v = x;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < aw) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// D-deep shift register carrying {valid, a, b} from the read side of a
// butterfly to the matching write-back cycle.
module fft_addr_delay
  import fft_pkg::*;
#(
  parameter int AW = 4,
  parameter int D  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] b_i,
  output logic          valid_o,
  output logic [AW-1:0] a_o,
  output logic [AW-1:0] b_o
);

  localparam int W = 1 + 2 * AW;

  logic [D*W-1:0] pipe_q;

  generate
    if (D == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= {valid_i, a_i, b_i};
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= {pipe_q[(D-1)*W-1:0], valid_i, a_i, b_i};
      end
    end
  endgenerate

  assign {valid_o, a_o, b_o} = pipe_q[D*W-1 -: W];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT on a dual-port complex RAM:
// bit-reversed load, per-stage butterfly issue with delayed write-back, natural-order unload.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter  int N          = 16,
  parameter  int RD_LATENCY = 1,
  parameter  int BF_LATENCY = 2,
  localparam int AW         = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] read_address1,
  output logic [AW-1:0] read_address2,
  output logic [AW-1:0] write_address1,
  output logic [AW-1:0] write_address2,
  output logic          wr_en,
  output logic          sel,
  output logic [AW-2:0] tw_index,
  output logic          out_valid,
  output logic [AW-1:0] out_index
);

  localparam int D  = RD_LATENCY + BF_LATENCY;
  localparam int DW = $clog2(D + 1);
  localparam int UW = $clog2(N + RD_LATENCY + 1) + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   loadCnt_q, loadCnt_d;
  logic [AW-1:0]   stage_q, stage_d;
  logic [AW-2:0]   bfly_q, bfly_d;
  logic            draining_q, draining_d;
  logic [DW-1:0]   drainCnt_q, drainCnt_d;
  logic [UW-1:0]   unloadCnt_q, unloadCnt_d;

  logic            issue;
  logic [AW-1:0]   kx, span, mask, addrA, addrB;
  logic            wbValid;
  logic [AW-1:0]   wbA, wbB;

  assign issue = (state_q == S_COMPUTE) && !draining_q;
  assign kx    = {1'b0, bfly_q};
  assign span  = AW'(1) << stage_q;
  assign mask  = span - AW'(1);
  assign addrA = ((kx >> stage_q) << (stage_q + 1'b1)) | (kx & mask);
  assign addrB = addrA + span;

  always_comb begin
    state_d     = state_q;
    loadCnt_d   = loadCnt_q;
    stage_d     = stage_q;
    bfly_d      = bfly_q;
    draining_d  = draining_q;
    drainCnt_d  = drainCnt_q;
    unloadCnt_d = unloadCnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          loadCnt_d = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          loadCnt_d = loadCnt_q + 1'b1;
          if (loadCnt_q == AW'(N - 1)) begin
            state_d    = S_COMPUTE;
            stage_d    = '0;
            bfly_d     = '0;
            draining_d = 1'b0;
            drainCnt_d = '0;
          end
        end
      end
      S_COMPUTE: begin
        // The drain window lets the last write of a stage land before the next stage reads.
        if (!draining_q) begin
          bfly_d = bfly_q + 1'b1;
          if (bfly_q == (AW-1)'(N / 2 - 1)) begin
            bfly_d     = '0;
            draining_d = 1'b1;
            drainCnt_d = '0;
          end
        end else begin
          drainCnt_d = drainCnt_q + 1'b1;
          if (drainCnt_q == DW'(D - 1)) begin
            draining_d = 1'b0;
            if (stage_q == AW'(AW - 1)) begin
              state_d     = S_UNLOAD;
              unloadCnt_d = '0;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end
        end
      end
      S_UNLOAD: begin
        unloadCnt_d = unloadCnt_q + 1'b1;
        if (unloadCnt_q == UW'(N + RD_LATENCY)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      loadCnt_q   <= '0;
      stage_q     <= '0;
      bfly_q      <= '0;
      draining_q  <= 1'b0;
      drainCnt_q  <= '0;
      unloadCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      loadCnt_q   <= loadCnt_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      draining_q  <= draining_d;
      drainCnt_q  <= drainCnt_d;
      unloadCnt_q <= unloadCnt_d;
    end
  end

  fft_addr_delay #(.AW(AW), .D(D)) u_addr_delay (
    .clk     (clk),
    .rst     (rst),
    .valid_i (issue),
    .a_i     (addrA),
    .b_i     (addrB),
    .valid_o (wbValid),
    .a_o     (wbA),
    .b_o     (wbB)
  );

  always_comb begin
    busy           = (state_q != S_IDLE);
    done           = 1'b0;
    read_address1  = '0;
    read_address2  = '0;
    write_address1 = '0;
    write_address2 = '0;
    wr_en          = 1'b0;
    sel            = SEL_EXT;
    tw_index       = '0;
    out_valid      = 1'b0;
    out_index      = '0;
    case (state_q)
      S_LOAD: begin
        wr_en          = in_valid;
        write_address1 = AW'(bitrev(32'(loadCnt_q), AW));
      end
      S_COMPUTE: begin
        if (issue) begin
          read_address1 = addrA;
          read_address2 = addrB;
          tw_index      = (AW-1)'((kx & mask) << (AW - 1 - stage_q));
        end
        if (wbValid) begin
          wr_en          = 1'b1;
          sel            = SEL_BF;
          write_address1 = wbA;
          write_address2 = wbB;
        end
      end
      S_UNLOAD: begin
        if (unloadCnt_q < UW'(N)) read_address1 = unloadCnt_q[AW-1:0];
        // Read data appears RD_LATENCY cycles after its address.
        if (unloadCnt_q >= UW'(RD_LATENCY) && unloadCnt_q < UW'(N + RD_LATENCY)) begin
          out_valid = 1'b1;
          out_index = AW'(unloadCnt_q - UW'(RD_LATENCY));
        end
        done = (unloadCnt_q == UW'(N + RD_LATENCY));
      end
      default: ;
    endcase
  end

endmodule
